// File: rtl/sprite_palette_pkg.sv
// Shared types and reset-default colour tables for the sprite palette controller.
package sprite_palette_pkg;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StFlashOn  = 2'd1,
    StFlashOff = 2'd2
  } flash_state_e;

  typedef logic [11:0] rgb12_t;

  localparam int unsigned DefaultEntries = 16;

  localparam rgb12_t DEFAULT_NORMAL [DefaultEntries] = '{
    12'h000, 12'hFFF, 12'h222, 12'h444, 12'h666, 12'h888, 12'hAAA, 12'hCCC,
    12'hF00, 12'h0F0, 12'h00F, 12'hFF0, 12'h0FF, 12'hF0F, 12'h840, 12'h48C
  };

  localparam rgb12_t DEFAULT_HURT [DefaultEntries] = '{
    12'h000, 12'hFFF, 12'hF22, 12'hF44, 12'hF66, 12'hF88, 12'hFAA, 12'hFCC,
    12'hF00, 12'hF80, 12'hF08, 12'hFF8, 12'hF8F, 12'hF0F, 12'hC40, 12'hE8C
  };

  // Entries beyond the 16-entry tables and banks above 1 default to black.
  function automatic rgb12_t default_rgb(input int unsigned bank, input int unsigned idx);
    logic [3:0] idx4;
    idx4 = idx[3:0];
    if (idx >= DefaultEntries) return '0;
    if (bank == 0) return DEFAULT_NORMAL[idx4];
    if (bank == 1) return DEFAULT_HURT[idx4];
    return '0;
  endfunction

endpackage

// File: rtl/sprite_palette_ctrl_flash_fsm.sv
// Hurt-flash sequencer: alternates FLASH_ON / FLASH_OFF phases counted in frames.
module palette_flash_fsm
  import sprite_palette_pkg::*;
#(
  parameter int unsigned FLASH_FRAMES = 4,
  parameter int unsigned NUM_FLASHES  = 3,
  parameter int unsigned NUM_BANKS    = 2,
  parameter int unsigned BANK_W       = 1
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              frame_start,
  input  logic              hurt_trig,
  output logic [BANK_W-1:0] req_bank,
  output logic              flashing
);

  localparam int unsigned FcntW = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
  localparam int unsigned NcntW = (NUM_FLASHES > 1) ? $clog2(NUM_FLASHES) : 1;
  localparam logic [FcntW-1:0] FrameReload = FcntW'(FLASH_FRAMES - 1);
  localparam logic [NcntW-1:0] FlashReload = NcntW'(NUM_FLASHES - 1);

  flash_state_e     state_q, state_d;
  logic [FcntW-1:0] fcnt_q, fcnt_d;
  logic [NcntW-1:0] ncnt_q, ncnt_d;
  logic             flashing_q;

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    ncnt_d  = ncnt_q;
    if (hurt_trig) begin
      // A hurt always restarts the full sequence, even mid-flash.
      state_d = StFlashOn;
      fcnt_d  = FrameReload;
      ncnt_d  = FlashReload;
    end else if (frame_start && (state_q != StIdle)) begin
      if (fcnt_q != '0) begin
        fcnt_d = fcnt_q - 1'b1;
      end else begin
        unique case (state_q)
          StFlashOn: begin
            state_d = StFlashOff;
            fcnt_d  = FrameReload;
          end
          StFlashOff: begin
            if (ncnt_q != '0) begin
              state_d = StFlashOn;
              ncnt_d  = ncnt_q - 1'b1;
              fcnt_d  = FrameReload;
            end else begin
              state_d = StIdle;
            end
          end
          default: state_d = StIdle;
        endcase
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q    <= StIdle;
      fcnt_q     <= '0;
      ncnt_q     <= '0;
      flashing_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fcnt_q     <= fcnt_d;
      ncnt_q     <= ncnt_d;
      flashing_q <= (state_d != StIdle);
    end
  end

  assign req_bank = ((state_q == StFlashOn) && (NUM_BANKS > 1)) ? BANK_W'(1) : '0;
  assign flashing = flashing_q;

endmodule

// File: rtl/sprite_palette_ctrl.sv
// Sprite colour lookup with a flip-flop palette and frame-aligned hurt-flash bank switching.
module sprite_palette_ctrl
  import sprite_palette_pkg::*;
#(
  parameter int unsigned IDX_W        = 4,
  parameter int unsigned NUM_BANKS    = 2,
  parameter int unsigned FLASH_FRAMES = 4,
  parameter int unsigned NUM_FLASHES  = 3,
  parameter int unsigned TRANSP_IDX   = 0,
  localparam int unsigned BANK_W      = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              pix_valid,
  input  logic [IDX_W-1:0]  index,
  input  logic              frame_start,
  input  logic              hurt_trig,
  input  logic              wr_en,
  input  logic [BANK_W-1:0] wr_bank,
  input  logic [IDX_W-1:0]  wr_index,
  input  logic [11:0]       wr_rgb,
  output logic [3:0]        red,
  output logic [3:0]        green,
  output logic [3:0]        blue,
  output logic              rgb_valid,
  output logic              transparent,
  output logic              flashing
);

  localparam int unsigned Entries = 2 ** IDX_W;

  rgb12_t            pal_q [NUM_BANKS][Entries];
  rgb12_t            pal_d [NUM_BANKS][Entries];
  logic [BANK_W-1:0] active_bank_q, active_bank_d;
  logic [BANK_W-1:0] req_bank;
  rgb12_t            rgb_q, rgb_d, rd_rgb;
  logic              rgb_valid_q, rgb_valid_d;
  logic              transp_q, transp_d;
  logic              wr_bank_ok;

  palette_flash_fsm #(
    .FLASH_FRAMES(FLASH_FRAMES),
    .NUM_FLASHES (NUM_FLASHES),
    .NUM_BANKS   (NUM_BANKS),
    .BANK_W      (BANK_W)
  ) u_flash_fsm (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .frame_start(frame_start),
    .hurt_trig  (hurt_trig),
    .req_bank   (req_bank),
    .flashing   (flashing)
  );

  assign wr_bank_ok = ({1'b0, wr_bank} < (BANK_W + 1)'(NUM_BANKS));

  always_comb begin
    pal_d = pal_q;
    if (wr_en && wr_bank_ok) begin
      pal_d[wr_bank][wr_index] = wr_rgb;
    end
  end

  always_comb begin
    // Reads see pal_q, so a same-cycle write to the entry returns the old colour.
    rd_rgb        = pal_q[active_bank_q][index];
    rgb_valid_d   = pix_valid;
    rgb_d         = pix_valid ? rd_rgb : '0;
    transp_d      = pix_valid && (index == IDX_W'(TRANSP_IDX));
    active_bank_d = frame_start ? req_bank : active_bank_q;
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        for (int i = 0; i < Entries; i++) begin
          pal_q[b][i] <= default_rgb(b, i);
        end
      end
    end else begin
      pal_q <= pal_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      active_bank_q <= '0;
      rgb_q         <= '0;
      rgb_valid_q   <= 1'b0;
      transp_q      <= 1'b0;
    end else begin
      active_bank_q <= active_bank_d;
      rgb_q         <= rgb_d;
      rgb_valid_q   <= rgb_valid_d;
      transp_q      <= transp_d;
    end
  end

  assign red         = rgb_q[11:8];
  assign green       = rgb_q[7:4];
  assign blue        = rgb_q[3:0];
  assign rgb_valid   = rgb_valid_q;
  assign transparent = transp_q;

endmodule
